// File: rtl/wb_mem_slave.sv
// wb_mem_slave: Wishbone classic slave over a 2**AW x 32-bit memory, random wait states from an 8-bit LFSR.
// Latency: ack 1..1+WAIT_MASK cycles after the request edge, one cycle wide; read data registered into dat_r.
// Backpressure: wait states stretch the cycle; master dropping cyc/stb in WAIT aborts. Macro WB_MEM_SLAVE_ERR_EN adds err.
module wb_mem_slave #(
   parameter logic [1:0] BASE      = 2'd0,
   parameter int         AW        = 6,
   parameter logic [7:0] WAIT_MASK = 8'h03,
   parameter logic [7:0] SEED      = 8'hA5
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [29:0] adr,
   input  logic [31:0] dat_w,
   output logic [31:0] dat_r,
   input  logic        we,
   input  logic [3:0]  sel,
   input  logic        cyc,
   input  logic        stb,
   output logic        ack,
`ifdef WB_MEM_SLAVE_ERR_EN
   output logic        err,
`endif
   output logic [15:0] rcount,
   output logic [15:0] wcount
);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_t;

   state_t       state_q, state_d;
   logic [7:0]   lfsr_q, lfsr_d;
   logic [7:0]   wcnt_q, wcnt_d;
   logic [27:0]  adr_q, adr_d;
   logic         we_q, we_d;
   logic [3:0]   sel_q, sel_d;
   logic [31:0]  dat_w_q, dat_w_d;
   logic         ack_q, ack_d;
   logic [31:0]  dat_r_q, dat_r_d;
   logic [15:0]  rcount_q, rcount_d;
   logic [15:0]  wcount_q, wcount_d;
   logic [31:0]  mem_q [2**AW];

   // Fields of the transfer being committed: live bus on a zero-wait request, captured copy otherwise.
   logic         req, commit, bad_adr, mem_wr;
   logic [27:0]  x_adr;
   logic         x_we;
   logic [3:0]   x_sel;
   logic [31:0]  x_dat;

`ifdef WB_MEM_SLAVE_ERR_EN
   logic         err_q, err_d;
`else
   // Upper word-address bits only matter for the range check; without it they alias.
   logic         unused_adr_bits;
   assign unused_adr_bits = ^x_adr[27:AW];
`endif

   // Request decode, wait-state sequencing and capture of the transfer fields.
   always_comb begin
      req     = cyc & stb & (adr[29:28] == BASE);
      lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      state_d = state_q;
      wcnt_d  = wcnt_q;
      adr_d   = adr_q;
      we_d    = we_q;
      sel_d   = sel_q;
      dat_w_d = dat_w_q;
      x_adr   = adr_q;
      x_we    = we_q;
      x_sel   = sel_q;
      x_dat   = dat_w_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               adr_d   = adr[27:0];
               we_d    = we;
               sel_d   = sel;
               dat_w_d = dat_w;
               x_adr   = adr[27:0];
               x_we    = we;
               x_sel   = sel;
               x_dat   = dat_w;
               wcnt_d  = lfsr_q & WAIT_MASK;
               if ((lfsr_q & WAIT_MASK) == 8'd0) begin
                  state_d = ACK;
                  commit  = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!(cyc && stb)) begin
               state_d = IDLE;
            end else begin
               wcnt_d = wcnt_q - 8'd1;
               if (wcnt_q == 8'd1) begin
                  state_d = ACK;
                  commit  = 1'b1;
               end
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Transfer outcome: ack or err, memory write strobe, read data and saturating counters.
   always_comb begin
`ifdef WB_MEM_SLAVE_ERR_EN
      bad_adr = (x_adr[27:AW] != '0);
      err_d   = commit & bad_adr;
`else
      bad_adr = 1'b0;
`endif
      ack_d    = commit & ~bad_adr;
      mem_wr   = ack_d & x_we & sys_rst_n;
      dat_r_d  = dat_r_q;
      rcount_d = rcount_q;
      wcount_d = wcount_q;
      if (ack_d) begin
         if (x_we) begin
            if (wcount_q != 16'hFFFF) wcount_d = wcount_q + 16'd1;
         end else begin
            dat_r_d = mem_q[x_adr[AW-1:0]];
            if (rcount_q != 16'hFFFF) rcount_d = rcount_q + 16'd1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_q <= IDLE;
      else            state_q <= state_d;
   end

   // Datapath registers; captured request fields are cleared too so nothing stale survives reset.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         lfsr_q   <= SEED;
         wcnt_q   <= 8'd0;
         adr_q    <= 28'd0;
         we_q     <= 1'b0;
         sel_q    <= 4'd0;
         dat_w_q  <= 32'd0;
         ack_q    <= 1'b0;
         dat_r_q  <= 32'd0;
         rcount_q <= 16'd0;
         wcount_q <= 16'd0;
`ifdef WB_MEM_SLAVE_ERR_EN
         err_q    <= 1'b0;
`endif
      end else begin
         lfsr_q   <= lfsr_d;
         wcnt_q   <= wcnt_d;
         adr_q    <= adr_d;
         we_q     <= we_d;
         sel_q    <= sel_d;
         dat_w_q  <= dat_w_d;
         ack_q    <= ack_d;
         dat_r_q  <= dat_r_d;
         rcount_q <= rcount_d;
         wcount_q <= wcount_d;
`ifdef WB_MEM_SLAVE_ERR_EN
         err_q    <= err_d;
`endif
      end
   end

   // Memory array has no reset so contents survive sys_rst_n; only lanes with sel set are written.
   always_ff @(posedge sys_clk) begin
      if (mem_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (x_sel[i]) mem_q[x_adr[AW-1:0]][8*i +: 8] <= x_dat[8*i +: 8];
         end
      end
   end

   assign ack    = ack_q;
   assign dat_r  = dat_r_q;
   assign rcount = rcount_q;
   assign wcount = wcount_q;
`ifdef WB_MEM_SLAVE_ERR_EN
   assign err    = err_q;
`endif

endmodule
